// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, branch flushes, mult/div tracking.
// Optional `HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_md_start,
    input  logic        id_md_read,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        md_go,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   md_cnt, md_cnt_next;
    logic               load_use;
    logic               md_hazard;
    logic               stall;

    // A load writing $0 never creates a real dependency.
    assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign md_hazard = (state == MD_BUSY) && (id_md_start || id_md_read);
    assign stall     = load_use || md_hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        md_go       = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        state_next  = state;
        md_cnt_next = md_cnt;

        // A taken branch squashes the ID instruction, so any stall it had is moot.
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        case (state)
            RUN: begin
                md_go = id_md_start && !stall && !ex_branch_taken;
                if (md_go) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = CNT_W'(MD_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (md_cnt == '0) begin
                    md_done    = 1'b1;
                    state_next = RUN;
                end else begin
                    md_cnt_next = md_cnt - CNT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (ex_branch_taken && (flush_events != '1))
                flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule
